instr_dispatcher: RTL and testbench
===================================

// Module: instr_dispatcher
// PURPOSE
//  Transmit end of the core instruction interface. It buffers 16-bit instruction words written by
//  the host/scheduler and streams them to one gpu core over the val_ins/instruction/rtr handshake.
//  Words are grouped into blocks, each closed by a word written with host_last. After the final
//  word of a block is accepted, the dispatcher waits for the core's ready and then pulses blk_done.
// PARAMETERS
//  DEPTH   16  instruction FIFO entries; must be a power of 2, >= 2
//  IW      16  instruction width: 4-bit opcode [15:12] plus 12-bit operand [11:0]
//  CW      5   width of fifo_count = log2(DEPTH)+1
// PORTS
//  clk          in   1   clock; all logic is rising-edge
//  reset        in   1   synchronous, active-high reset
//  host_wr      in   1   push host_data into the FIFO this cycle
//  host_data    in   IW  instruction word to push
//  host_last    in   1   pushed word closes the current block
//  host_full    out  1   FIFO full; a push in this cycle is dropped
//  overflow     out  1   sticky flag: a push occurred while full; cleared only by reset
//  fifo_count   out  CW  number of words currently in the FIFO
//  val_ins      out  1   instruction output is valid
//  instruction  out  IW  instruction word to the core
//  rtr          in   1   core ready-to-receive; transfer happens when val_ins && rtr
//  ready        in   1   core idle / finished executing
//  busy         out  1   state != IDLE
//  blk_done     out  1   one-cycle pulse: block fully delivered and core ready
// BEHAVIOUR
//  Reset: val_ins=0, instruction=0, blk_done=0, busy=0, overflow=0, fifo_count=0, host_full=0.
//    FIFO pointers and blk_pend are cleared; state=IDLE. Reset mid-block discards all words.
//  FIFO: 1+IW bits per entry ({last,data}). host_full = (count==DEPTH).
//    Push and pop in the same cycle are both honoured: count is unchanged and the pointers
//    advance and wrap modulo DEPTH. A push when full is ignored and sets overflow.
//    A push while full combined with a same-cycle pop is still dropped (full is sampled pre-edge).
//  blk_pend counter: +1 on an accepted push with host_last, -1 on a pop of a last-tagged entry.
//    Both events in the same cycle leave it unchanged.
//  Output register: a load happens when (state==STREAM) && fifo not empty && (!val_ins || rtr).
//    On a load, instruction <= fifo data and val_ins <= 1 at the next edge.
//    val_ins && rtr && no load -> val_ins <= 0.
//    While val_ins && !rtr, instruction and val_ins hold stable (no change permitted).
//    Sustained throughput is 1 word/cycle when rtr is held at 1.
//  FSM:
//    IDLE   : blk_pend!=0 -> STREAM.
//    STREAM : load words; a load of a last-tagged word -> DRAIN (no further pops).
//    DRAIN  : wait until val_ins && rtr (last word accepted) -> WAIT.
//    WAIT   : ready==1 -> blk_done=1 for one cycle, then IDLE. ready is sampled only in WAIT.
//  Latency: a host_last push at edge N sets blk_pend at N. The FSM enters STREAM at N+1, the
//    first load happens at N+2, and val_ins is high from N+2.
//  The host may keep pushing the next block during STREAM, DRAIN and WAIT. That block starts
//    only after returning to IDLE: blk_done to the next val_ins takes at least 2 cycles.
//  An empty FIFO during STREAM (impossible while blk_pend!=0) leaves the FSM waiting in STREAM.
// TESTING
//  1. Push 16 words 0xC000..0xC00F (last on 0xC00F), rtr=1, ready=1 -> val_ins high 16
//     consecutive cycles, words in order, one blk_done pulse 2 cycles after the last accept.
//  2. Same block with rtr toggling 1,0,0,1... -> each word held stable while rtr=0; no word
//     lost or duplicated; 16 transfers total.
//  3. ready=0 after the last word is accepted, raised 50 cycles later -> busy stays 1;
//     blk_done fires exactly 1 cycle after ready rises.
//  4. Push 17 words with rtr=0 -> host_full=1 at count 16, 17th word dropped, overflow=1
//     (sticky); fifo_count=16.
//  5. Push and pop simultaneously across pointer wrap (40 words, DEPTH 16, rtr=1) -> fifo_count
//     stays constant during overlap, output order intact.
//  6. Assert reset mid-STREAM after 5 of 16 words -> next cycle val_ins=0, fifo_count=0,
//     busy=0, no blk_done; a following fresh block streams normally.

Source files
------------

// File: rtl/instr_dispatcher_if.sv
// Host-side push port and core-side instruction handshake of the instruction dispatcher.
// master = host/scheduler plus core (stimulus side), slave = dispatcher.
interface instr_dispatcher_if #(
   parameter int IW = 16,
   parameter int CW = 5
);
   logic          host_wr;
   logic [IW-1:0] host_data;
   logic          host_last;
   logic          host_full;
   logic          overflow;
   logic [CW-1:0] fifo_count;
   logic          val_ins;
   logic [IW-1:0] instruction;
   logic          rtr;
   logic          ready;
   logic          busy;
   logic          blk_done;

   modport master (
      output host_wr, host_data, host_last, rtr, ready,
      input  host_full, overflow, fifo_count, val_ins, instruction, busy, blk_done
   );

   modport slave (
      input  host_wr, host_data, host_last, rtr, ready,
      output host_full, overflow, fifo_count, val_ins, instruction, busy, blk_done
   );
endinterface

// File: rtl/instr_dispatcher.sv
// Buffers host instruction words in a FIFO and streams them block by block to one core,
// pulsing blk_done once the last word of a block is accepted and the core reports ready.
module instr_dispatcher #(
   parameter int DEPTH = 16,
   parameter int IW    = 16,
   parameter int CW    = 5
) (
   input  logic              clk,
   input  logic              reset,
   instr_dispatcher_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT} state_t;

   state_t        state, state_nx;
   logic [IW:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, blk_pend;
   logic          full, empty, push, load, head_last;
   logic          val_q, ovf_q, done_q, done_nx;
   logic [IW-1:0] instr_q;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign push      = bus.host_wr && !full;
   assign head_last = mem[rd_ptr][IW];
   // A load both pops the FIFO head and refills the output register.
   assign load      = (state == STREAM) && !empty && (!val_q || bus.rtr);

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      case (state)
         IDLE:    if (blk_pend != '0) state_nx = STREAM;
         STREAM:  if (load && head_last) state_nx = DRAIN;
         DRAIN:   if (val_q && bus.rtr) state_nx = WAIT;
         WAIT: begin
            if (bus.ready) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         blk_pend <= '0;
         val_q    <= 1'b0;
         instr_q  <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= done_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         case ({push, load})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         case ({push && bus.host_last, load && head_last})
            2'b10:   blk_pend <= blk_pend + 1'b1;
            2'b01:   blk_pend <= blk_pend - 1'b1;
            default: ;
         endcase
         if (bus.host_wr && full) ovf_q <= 1'b1;
         if (load) begin
            instr_q <= mem[rd_ptr][IW-1:0];
            val_q   <= 1'b1;
         end else if (val_q && bus.rtr) begin
            val_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.host_last, bus.host_data};
   end

   assign bus.host_full   = full;
   assign bus.overflow    = ovf_q;
   assign bus.fifo_count  = count;
   assign bus.val_ins     = val_q;
   assign bus.instruction = instr_q;
   assign bus.busy        = (state != IDLE);
   assign bus.blk_done    = done_q;
endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: streaming, back-pressure, ready wait, overflow, wrap, reset.
module tb_instr_dispatcher;
   logic clk;
   logic reset;
   int   npass  = 0;
   int   nfail  = 0;
   int   ntotal = 0;

   instr_dispatcher_if #(.IW(16), .CW(5)) bus ();

   instr_dispatcher #(.DEPTH(16), .IW(16), .CW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic push_block(input logic [15:0] base, input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         bus.host_wr   = 1'b1;
         bus.host_data = base + i[15:0];
         bus.host_last = with_last && (i == n - 1);
         tick();
      end
      bus.host_wr   = 1'b0;
      bus.host_last = 1'b0;
      bus.host_data = '0;
   endtask

   // Acts as the core: rtr either steady 1 or 1,0,0 repeating; checks order and stability.
   task automatic recv(input int n, input logic [15:0] base, input bit toggle, input bit want_done);
      int          got, dones, c;
      bit          held;
      logic [15:0] hold_word;
      logic        rtr_v;
      got = 0; dones = 0; c = 0; held = 0; hold_word = '0;
      while (c < 600 && (got < n || (want_done && dones == 0))) begin
         if (held) chk("hold_stable", {15'd0, bus.val_ins, bus.instruction}, {15'd0, 1'b1, hold_word});
         if (bus.blk_done) dones++;
         rtr_v   = toggle ? (c % 3 == 0) : 1'b1;
         bus.rtr = rtr_v;
         held    = 0;
         if (bus.val_ins && rtr_v) begin
            chk("word_order", {16'd0, bus.instruction}, {16'd0, base + got[15:0]});
            got++;
         end else if (bus.val_ins) begin
            held      = 1;
            hold_word = bus.instruction;
         end
         tick();
         c++;
      end
      chk("xfer_count", got, n);
      if (want_done) chk("blk_done_once", dones, 1);
   endtask

   initial begin
      int          pushed, got, dones, prev_cnt;
      bit          do_push, bad;

      reset = 1'b1;
      bus.host_wr = 1'b0; bus.host_data = '0; bus.host_last = 1'b0;
      bus.rtr = 1'b0; bus.ready = 1'b1;
      tick();
      tick();
      chk("rst_val_ins", bus.val_ins, 0);
      chk("rst_instruction", bus.instruction, 0);
      chk("rst_blk_done", bus.blk_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_fifo_count", bus.fifo_count, 0);
      chk("rst_host_full", bus.host_full, 0);
      reset = 1'b0;

      // 1: full block, rtr=1, ready=1
      push_block(16'hC000, 16, 1);
      chk("t1_count16", bus.fifo_count, 16);
      chk("t1_full", bus.host_full, 1);
      chk("t1_idle_busy", bus.busy, 0);
      bus.rtr = 1'b1;
      tick();
      chk("t1_stream_busy", bus.busy, 1);
      chk("t1_no_val_yet", bus.val_ins, 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("t1_val", bus.val_ins, 1);
         chk("t1_word", bus.instruction, 32'hC000 + i);
         if (i == 0) chk("t1_count15", bus.fifo_count, 15);
      end
      tick();
      chk("t1_val_drop", bus.val_ins, 0);
      chk("t1_done_early", bus.blk_done, 0);
      tick();
      chk("t1_done", bus.blk_done, 1);
      chk("t1_busy_off", bus.busy, 0);
      tick();
      chk("t1_done_pulse", bus.blk_done, 0);

      // 2: rtr toggling 1,0,0
      bus.rtr = 1'b0;
      push_block(16'hC000, 16, 1);
      recv(16, 16'hC000, 1, 1);
      chk("t2_done_clear", bus.blk_done, 0);

      // 3: ready low after last accept, raised 50 cycles later
      bus.ready = 1'b0;
      bus.rtr   = 1'b0;
      push_block(16'hC100, 16, 1);
      recv(16, 16'hC100, 0, 0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (!bus.busy || bus.blk_done) bad = 1;
         tick();
      end
      chk("t3_wait_busy", bad, 0);
      chk("t3_no_done", bus.blk_done, 0);
      bus.ready = 1'b1;
      tick();
      chk("t3_done", bus.blk_done, 1);
      chk("t3_busy_off", bus.busy, 0);
      tick();
      chk("t3_done_pulse", bus.blk_done, 0);

      // 4: overflow with rtr=0 and no block boundary
      bus.rtr = 1'b0;
      push_block(16'h4000, 16, 0);
      chk("t4_count16", bus.fifo_count, 16);
      chk("t4_full", bus.host_full, 1);
      chk("t4_no_ovf", bus.overflow, 0);
      push_block(16'h4010, 1, 0);
      chk("t4_ovf", bus.overflow, 1);
      chk("t4_count_hold", bus.fifo_count, 16);
      tick();
      chk("t4_ovf_sticky", bus.overflow, 1);
      chk("t4_no_stream", bus.val_ins, 0);
      do_reset();
      chk("t4_rst_ovf", bus.overflow, 0);
      chk("t4_rst_count", bus.fifo_count, 0);

      // 5: 40 words in blocks of 8, concurrent push/pop across pointer wrap
      bus.rtr = 1'b1;
      pushed = 0; got = 0; dones = 0; prev_cnt = 0;
      for (int c = 0; c < 400 && got < 40; c++) begin
         do_push       = (pushed < 40) && !bus.host_full;
         bus.host_wr   = do_push;
         bus.host_data = 16'h5000 + pushed[15:0];
         bus.host_last = (pushed % 8 == 7);
         tick();
         if (do_push) pushed++;
         if (bus.val_ins) begin
            chk("t5_word", bus.instruction, 32'h5000 + got);
            got++;
            if (do_push) chk("t5_count_const", bus.fifo_count, prev_cnt);
         end
         if (bus.blk_done) dones++;
         prev_cnt = int'(bus.fifo_count);
      end
      bus.host_wr = 1'b0; bus.host_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.blk_done) dones++;
      end
      chk("t5_got", got, 40);
      chk("t5_dones", dones, 5);
      chk("t5_empty", bus.fifo_count, 0);
      chk("t5_no_ovf", bus.overflow, 0);

      // 6: reset mid-stream, then a fresh block
      bus.rtr = 1'b0;
      push_block(16'hA000, 16, 1);
      recv(5, 16'hA000, 0, 0);
      do_reset();
      chk("t6_val_ins", bus.val_ins, 0);
      chk("t6_count", bus.fifo_count, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_done", bus.blk_done, 0);
      tick();
      tick();
      chk("t6_stay_idle", bus.busy, 0);
      chk("t6_no_done", bus.blk_done, 0);
      bus.rtr = 1'b0;
      push_block(16'hB000, 16, 1);
      recv(16, 16'hB000, 0, 1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
